// File: rtl/hilo_mac_pkg.sv
// Shared definitions for the HI/LO multiply / multiply-accumulate sequencer:
// op encodings, sequencer states, datapath widths and op-decode helpers.
package hilo_mac_pkg;

  localparam int REG_W  = 32;
  localparam int DREG_W = 64;

  // Op codes presented on op_i; 3'd6 and 3'd7 are unassigned.
  localparam logic [2:0] MAC_MULT  = 3'd0;
  localparam logic [2:0] MAC_MULTU = 3'd1;
  localparam logic [2:0] MAC_MADD  = 3'd2;
  localparam logic [2:0] MAC_MADDU = 3'd3;
  localparam logic [2:0] MAC_MSUB  = 3'd4;
  localparam logic [2:0] MAC_MSUBU = 3'd5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    ACC  = 2'd2,
    DONE = 2'd3
  } state_e;

  function automatic logic op_valid(input logic [2:0] op);
    return (op <= MAC_MSUBU);
  endfunction

  function automatic logic op_signed(input logic [2:0] op);
    return (op == MAC_MULT) || (op == MAC_MADD) || (op == MAC_MSUB);
  endfunction

  function automatic logic op_acc(input logic [2:0] op);
    return (op == MAC_MADD) || (op == MAC_MADDU) || (op == MAC_MSUB) || (op == MAC_MSUBU);
  endfunction

  function automatic logic op_sub(input logic [2:0] op);
    return (op == MAC_MSUB) || (op == MAC_MSUBU);
  endfunction

endpackage

// File: rtl/hilo_mac_mul_pipe.sv
// Unsigned 32x32->64 multiplier, MUL_STAGES register stages deep.
// Stage 0 registers the full product; the remaining stages only delay it,
// leaving retiming free to spread the multiplier across them.
module mul_pipe
  import hilo_mac_pkg::*;
#(
  parameter int MUL_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              vld_in,
  input  logic [REG_W-1:0]  a,
  input  logic [REG_W-1:0]  b,
  output logic              vld_out,
  output logic [DREG_W-1:0] p
);

  logic [DREG_W-1:0]   prod_p [MUL_STAGES];
  logic [MUL_STAGES-1:0] vld_p;

  // Product and valid shift register; clr drops every in-flight valid.
  always_ff @(posedge clk) begin
    if (!rst) begin
      vld_p <= '0;
      for (int i = 0; i < MUL_STAGES; i++) prod_p[i] <= '0;
    end else begin
      vld_p[0]  <= vld_in && !clr;
      prod_p[0] <= {{(DREG_W-REG_W){1'b0}}, a} * {{(DREG_W-REG_W){1'b0}}, b};
      for (int i = 1; i < MUL_STAGES; i++) begin
        vld_p[i]  <= vld_p[i-1] && !clr;
        prod_p[i] <= prod_p[i-1];
      end
    end
  end

  assign vld_out = vld_p[MUL_STAGES-1];
  assign p       = prod_p[MUL_STAGES-1];

endmodule

// File: rtl/hilo_mac_seq.sv
// EX-stage sequencer for MULT/MULTU/MADD/MADDU/MSUB/MSUBU.
// Feeds operand magnitudes to mul_pipe, restores the sign, accumulates into
// the forwarded HI/LO value and stalls EX until the result sits in DONE.
// DONE is held under hold_i so an accumulate is never applied twice.
// Optional build macro: HILO_MAC_ZERO_SKIP_EN (bypass the multiplier when
// either operand is zero; results are identical, only latency changes).
module hilo_mac_seq
  import hilo_mac_pkg::*;
#(
  parameter int MUL_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic [2:0]        op_i,
  input  logic [REG_W-1:0]  opa_i,
  input  logic [REG_W-1:0]  opb_i,
  input  logic [DREG_W-1:0] hilo_i,
  input  logic              hold_i,
  input  logic              flush_i,
  output logic              stallreq_o,
  output logic              whilo_o,
  output logic [REG_W-1:0]  hi_o,
  output logic [REG_W-1:0]  lo_o,
  output logic              busy_o
);

  localparam logic [2:0] LAST_CNT = 3'(MUL_STAGES - 1);

  state_e            state, state_nx;
  logic [2:0]        cnt;
  logic [2:0]        op_q;
  logic              neg_q;
  logic [DREG_W-1:0] prod_q;
  logic [DREG_W-1:0] result_q;

  logic              accept;
  logic              zero_skip;
  logic              neg_nx;
  logic [REG_W-1:0]  mag_a, mag_b;
  logic              mul_vld;
  logic [DREG_W-1:0] mul_p;
  logic              mul_last;

  // Two's-complement magnitude; 0x80000000 maps to 2^31 unsigned.
  function automatic logic [REG_W-1:0] magnitude(input logic [REG_W-1:0] x, input logic sgn);
    return (sgn && x[REG_W-1]) ? (~x + 1'b1) : x;
  endfunction

  // Conditional 64-bit negation used for both sign restore and subtract.
  function automatic logic [DREG_W-1:0] fix_sign(input logic [DREG_W-1:0] x, input logic neg);
    return neg ? (~x + 1'b1) : x;
  endfunction

  assign accept = (state == IDLE) && start_i && !flush_i && op_valid(op_i);
`ifdef HILO_MAC_ZERO_SKIP_EN
  assign zero_skip = (opa_i == '0) || (opb_i == '0);
`else
  assign zero_skip = 1'b0;
`endif
  // Product sign flips for differing signed operands, and once more for MSUB*.
  assign neg_nx = (op_signed(op_i) && (opa_i[REG_W-1] ^ opb_i[REG_W-1])) ^ op_sub(op_i);
  assign mag_a  = magnitude(opa_i, op_signed(op_i));
  assign mag_b  = magnitude(opb_i, op_signed(op_i));

  mul_pipe #(
    .MUL_STAGES (MUL_STAGES)
  ) u_mul (
    .clk     (clk),
    .rst     (rst),
    .clr     (flush_i),
    .vld_in  (accept && !zero_skip),
    .a       (mag_a),
    .b       (mag_b),
    .vld_out (mul_vld),
    .p       (mul_p)
  );

  assign mul_last = (state == MUL) && (cnt == LAST_CNT) && mul_vld;

  // State, capture and result registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      cnt      <= '0;
      op_q     <= '0;
      neg_q    <= 1'b0;
      prod_q   <= '0;
      result_q <= '0;
    end else begin
      state <= state_nx;
      cnt   <= (state == MUL) ? cnt + 3'd1 : 3'd0;
      case (state)
        IDLE: begin
          if (accept) begin
            op_q  <= op_i;
            neg_q <= neg_nx;
            if (zero_skip) begin
              prod_q   <= '0;
              result_q <= '0;
            end
          end
        end
        MUL: begin
          if (mul_last) begin
            prod_q   <= fix_sign(mul_p, neg_q);
            result_q <= fix_sign(mul_p, neg_q);
          end
        end
        ACC:     result_q <= hilo_i + prod_q;
        default: ;
      endcase
    end
  end

  // Next state and outputs; flush and reset override the state decode.
  always_comb begin
    state_nx   = state;
    stallreq_o = 1'b0;
    whilo_o    = 1'b0;
    hi_o       = '0;
    lo_o       = '0;
    case (state)
      IDLE: begin
        stallreq_o = accept;
        if (accept) begin
          if (zero_skip) state_nx = op_acc(op_i) ? ACC : DONE;
          else           state_nx = MUL;
        end
      end
      MUL: begin
        stallreq_o = 1'b1;
        if (mul_last) state_nx = op_acc(op_q) ? ACC : DONE;
      end
      ACC: begin
        stallreq_o = 1'b1;
        state_nx   = DONE;
      end
      DONE: begin
        whilo_o = 1'b1;
        hi_o    = result_q[DREG_W-1:REG_W];
        lo_o    = result_q[REG_W-1:0];
        if (!hold_i) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
    if (flush_i) begin
      state_nx   = IDLE;
      stallreq_o = 1'b0;
      whilo_o    = 1'b0;
    end
    if (!rst) begin
      stallreq_o = 1'b0;
      whilo_o    = 1'b0;
      hi_o       = '0;
      lo_o       = '0;
    end
  end

  assign busy_o = (state != IDLE);

endmodule

// File: tb/tb_hilo_mac_seq.sv
// Self-checking bench for hilo_mac_seq: a reference model pushes expected
// results and stall counts into a scoreboard queue when an op is issued,
// and each scenario pops and compares when whilo_o appears.
module tb_hilo_mac_seq;

  localparam int MUL_STAGES = 2;

  logic        clk;
  logic        rst;
  logic        start_i;
  logic [2:0]  op_i;
  logic [31:0] opa_i, opb_i;
  logic [63:0] hilo_i;
  logic        hold_i, flush_i;
  logic        stallreq_o, whilo_o, busy_o;
  logic [31:0] hi_o, lo_o;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [63:0] res;
    int          stalls;
  } exp_t;
  exp_t sbq[$];

  hilo_mac_seq #(.MUL_STAGES(MUL_STAGES)) dut (
    .clk        (clk),
    .rst        (rst),
    .start_i    (start_i),
    .op_i       (op_i),
    .opa_i      (opa_i),
    .opb_i      (opb_i),
    .hilo_i     (hilo_i),
    .hold_i     (hold_i),
    .flush_i    (flush_i),
    .stallreq_o (stallreq_o),
    .whilo_o    (whilo_o),
    .hi_o       (hi_o),
    .lo_o       (lo_o),
    .busy_o     (busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] a,
                                        input logic [31:0] b, input logic [63:0] h);
    logic [63:0] sa, sb, ua, ub, ps, pu;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ua = {32'd0, a};
    ub = {32'd0, b};
    ps = sa * sb;
    pu = ua * ub;
    case (op)
      3'd0:    return ps;
      3'd1:    return pu;
      3'd2:    return h + ps;
      3'd3:    return h + pu;
      3'd4:    return h - ps;
      3'd5:    return h - pu;
      default: return h;
    endcase
  endfunction

  function automatic int exp_stalls(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    int acc;
    acc = (op >= 3'd2) ? 1 : 0;
`ifdef HILO_MAC_ZERO_SKIP_EN
    if (a == 0 || b == 0) return 1 + acc;
`endif
    return MUL_STAGES + 1 + acc;
  endfunction

  // Issue one op, wait for DONE, compare, optionally hold DONE for hold_n cycles.
  task automatic run_op(input string name, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [63:0] h, input int hold_n);
    exp_t e;
    int   stalls;
    bit   done;
    logic [63:0] got;
    e.res    = model(op, a, b, h);
    e.stalls = exp_stalls(op, a, b);
    sbq.push_back(e);
    @(posedge clk); #1;
    start_i = 1'b1; op_i = op; opa_i = a; opb_i = b; hilo_i = h;
    hold_i = 1'b0; flush_i = 1'b0;
    stalls = 0;
    done   = 1'b0;
    for (int c = 0; c < 40 && !done; c++) begin
      @(negedge clk);
      if (whilo_o) done = 1'b1;
      else if (stallreq_o) stalls++;
      // Operand changes after capture must not reach the result.
      if (c == 1 && !done) begin
        opa_i = $urandom; opb_i = $urandom; op_i = 3'($urandom_range(0, 5));
      end
    end
    got = {hi_o, lo_o};
    e   = sbq.pop_front();
    total++;
    if (!done) begin
      bad++;
      $display("FAIL %s timeout: whilo_o=%0b after 40 cycles, required 1", name, whilo_o);
      start_i = 1'b0;
    end else begin
      total++;
      if (got !== e.res) begin
        bad++;
        $display("FAIL %s result: got %h required %h", name, got, e.res);
      end
      total++;
      if (stalls !== e.stalls || stallreq_o !== 1'b0) begin
        bad++;
        $display("FAIL %s stall: got %0d cycles (stallreq in DONE=%0b) required %0d", name, stalls, stallreq_o, e.stalls);
      end
      start_i = 1'b0;
      hold_i  = (hold_n > 0);
      for (int k = 0; k < hold_n; k++) begin
        hilo_i = {$urandom, $urandom};
        @(negedge clk);
        total++;
        if (whilo_o !== 1'b1 || {hi_o, lo_o} !== e.res) begin
          bad++;
          $display("FAIL %s hold%0d: whilo=%0b result=%h required whilo=1 result=%h", name, k, whilo_o, {hi_o, lo_o}, e.res);
        end
        if (k == hold_n - 1) hold_i = 1'b0;
      end
      @(negedge clk);
      total++;
      if (whilo_o !== 1'b0 || busy_o !== 1'b0) begin
        bad++;
        $display("FAIL %s release: whilo=%0b busy=%0b required 0 0", name, whilo_o, busy_o);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; start_i = 1'b1; op_i = 3'd2; opa_i = 32'd3; opb_i = 32'd4;
    hilo_i = 64'd9; hold_i = 1'b0; flush_i = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++;
    if ({stallreq_o, whilo_o, busy_o, hi_o, lo_o} !== '0) begin
      bad++;
      $display("FAIL reset_outputs: stall=%0b whilo=%0b busy=%0b hi=%h lo=%h required all 0", stallreq_o, whilo_o, busy_o, hi_o, lo_o);
    end
    start_i = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    total++;
    if ({stallreq_o, whilo_o, busy_o} !== 3'b000) begin
      bad++;
      $display("FAIL reset_release: stall=%0b whilo=%0b busy=%0b required 0 0 0", stallreq_o, whilo_o, busy_o);
    end
  endtask

  task automatic test_mult();
    run_op("mult_min_sq", 3'd0, 32'h8000_0000, 32'h8000_0000, 64'd0, 0);
    run_op("mult_neg",    3'd0, 32'hFFFF_FFFD, 32'd5, 64'd0, 0);
    run_op("multu_max",   3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'd0, 0);
  endtask

  task automatic test_accumulate();
    run_op("madd_wrap",   3'd2, 32'd3, 32'hFFFF_FFFE, 64'h0000_0000_0000_0005, 0);
    run_op("msubu",       3'd5, 32'hFFFF_FFFF, 32'd2, 64'h0000_0001_0000_0000, 0);
    run_op("maddu",       3'd3, 32'h1234_5678, 32'h9ABC_DEF0, 64'hFFFF_FFFF_FFFF_FFF0, 0);
    run_op("msub_signed", 3'd4, 32'h8000_0000, 32'h7FFF_FFFF, 64'h0123_4567_89AB_CDEF, 0);
  endtask

  task automatic test_hold();
    run_op("madd_hold", 3'd2, 32'd1000, 32'hFFFF_FC18, 64'h0000_0002_0000_0000, 3);
  endtask

  task automatic test_flush();
    @(posedge clk); #1;
    start_i = 1'b1; op_i = 3'd4; opa_i = 32'd11; opb_i = 32'd13; hilo_i = 64'd100;
    @(negedge clk);
    @(posedge clk); #1;
    @(posedge clk); #1;
    flush_i = 1'b1;
    @(negedge clk);
    total++;
    if (stallreq_o !== 1'b0 || whilo_o !== 1'b0) begin
      bad++;
      $display("FAIL flush_cycle: stall=%0b whilo=%0b required 0 0", stallreq_o, whilo_o);
    end
    @(posedge clk); #1;
    flush_i = 1'b0; start_i = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      total++;
      if (busy_o !== 1'b0 || whilo_o !== 1'b0) begin
        bad++;
        $display("FAIL flush_after%0d: busy=%0b whilo=%0b required 0 0", k, busy_o, whilo_o);
      end
    end
    run_op("multu_after_flush", 3'd1, 32'd7, 32'd6, 64'd0, 0);
  endtask

  task automatic test_unknown_op();
    @(posedge clk); #1;
    start_i = 1'b1; op_i = 3'd7; opa_i = 32'd5; opb_i = 32'd5;
    @(negedge clk);
    total++;
    if (stallreq_o !== 1'b0) begin
      bad++;
      $display("FAIL unknown_op_stall: got %0b required 0", stallreq_o);
    end
    @(negedge clk);
    total++;
    if (busy_o !== 1'b0) begin
      bad++;
      $display("FAIL unknown_op_busy: got %0b required 0", busy_o);
    end
    start_i = 1'b0;
  endtask

  task automatic test_reset_mid_op();
    @(posedge clk); #1;
    start_i = 1'b1; op_i = 3'd2; opa_i = 32'd9; opb_i = 32'd9; hilo_i = 64'd1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0; start_i = 1'b0;
    @(negedge clk);
    total++;
    if ({stallreq_o, whilo_o, busy_o, hi_o, lo_o} !== '0) begin
      bad++;
      $display("FAIL reset_mid_op: stall=%0b whilo=%0b busy=%0b hi=%h lo=%h required all 0", stallreq_o, whilo_o, busy_o, hi_o, lo_o);
    end
    rst = 1'b1;
    run_op("madd_after_reset", 3'd2, 32'd9, 32'd9, 64'd1, 0);
  endtask

  task automatic test_zero_skip();
    run_op("mult_zero",  3'd0, 32'd0, 32'h0000_1234, 64'd0, 0);
    run_op("madd_zero",  3'd2, 32'd5, 32'd0, 64'h0000_0003_0000_0007, 0);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 8; i++) begin
      run_op($sformatf("b2b_%0d", i), 3'($urandom_range(0, 5)), $urandom, $urandom,
             {$urandom, $urandom}, i % 2);
    end
  endtask

  initial begin
    test_reset();
    test_mult();
    test_accumulate();
    test_hold();
    test_flush();
    test_unknown_op();
    test_reset_mid_op();
    test_zero_skip();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
